control_unit_np: RTL and testbench
==================================

Name: control_unit_np

Overview:
- Next-generation host command controller: byte-serial command stream in, strobes to N rotating DSP pipelines out.
- Generalises the two-pipeline controller to N_PIPES pipelines and parametrised data/instruction widths.
- Adds in_ready backpressure and a one-byte ACK/NAK response channel per command.
- Sits between the host byte link (UART/SPI deserialiser) and the pipeline array.

Parameters:
N_PIPES, 2, number of pipelines (>=2); PW = max(1, clog2(N_PIPES))
N_BLOCKS, 256, blocks per pipeline; BB = (N_BLOCKS>256) ? 2 : 1 block-address bytes
DATA_WIDTH, 16, register/gain width; DB = ceil(DATA_WIDTH/8)
INSTR_WIDTH, 32, block instruction width (multiple of 8); IB = INSTR_WIDTH/8
TIMEOUT_CYCLES, 1000000, idle cycles while programming before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_byte  in  8  command/payload byte
in_valid  in  1  in_byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
block_target  out  clog2(N_BLOCKS)  target block
reg_target  out  1  register select (0/1)
instr_out  out  INSTR_WIDTH  instruction word
data_out  out  DATA_WIDTH  register/gain value
delay_size_out, init_delay_out  out  24 each  delay allocation
block_instr_write, block_reg_write, reg_writes_commit, alloc_delay  out  N_PIPES each  one-cycle per-pipe strobes
pipe_full_reset  out  N_PIPES  one-cycle per-pipe reset request
pipe_enables  out  N_PIPES  level enables
regfile_syncing, pipe_resetting  in  N_PIPES each  per-pipe status
swap_req  out  1  one-cycle swap request
swap_busy  in  1  swap in progress
front_pipe, back_pipe  out  PW each  live pipe; pipe being programmed
set_input_gain, set_output_gain  out  1 each  one-cycle strobes
resp_byte  out  8  response code
resp_valid  out  1  held until resp_ready
resp_ready  in  1  response consumed
control_state  out  8  {zero-pad, state}

Behaviour:
- Reset (async): state IDLE, every strobe 0, front_pipe=0, back_pipe=1, pipe_enables=1 (bit0 only), programming=0, resp_valid=0. pipe_full_reset is all-ones while reset_n=0 and for the first clk after release, then 0.
- States: IDLE=0, LISTEN=1, EXECUTE=2, RESP=3, SWAP_WAIT=4, RESET_WAIT=5.
- in_ready=1 only in IDLE/LISTEN with resp_valid=0.
- IDLE opcodes (controller.vh COMMAND_* codes):
  - BEGIN_PROGRAM: programming=1; ACK.
  - WRITE_BLOCK_INSTR: BB+IB payload bytes.
  - WRITE_BLOCK_REG_0/1: BB+DB bytes.
  - ALLOC_DELAY: 6 bytes.
  - These three: if programming=0, NAK 0x02 immediately, no payload consumed.
  - UPDATE_BLOCK_REG_0/1: BB+DB bytes; target front_pipe.
  - SET_INPUT/OUTPUT_GAIN: DB bytes.
  - COMMIT_REG_UPDATES: reg_writes_commit[front_pipe] pulse; ACK.
  - END_PROGRAM: see swap sequence. If not programming, NAK 0x02.
  - Other opcodes: NAK 0x01.
- Payload: big-endian; block field first, then value. ALLOC: size (3 bytes), then init (3 bytes). Data truncated to DATA_WIDTH LSBs.
- EXECUTE: outputs and strobe issued in one cycle, then RESP.
  - Reg writes stall while swap_busy or regfile_syncing[target pipe].
  - Instr/alloc/reg-write strobes go to back_pipe.
- RESP: resp_valid=1 with code until resp_ready, then IDLE. Codes: 0x00 ACK, 0x01 unknown, 0x02 not programming, 0x03 timeout, 0x04 checksum.
- Swap sequence:
  - END_PROGRAM (programming): swap_req, reg_writes_commit[back], pipe_enables[back]=1; programming=0; go to SWAP_WAIT.
  - SWAP_WAIT: ignore swap_busy on entry cycle; when low: front<=back, back<=(back+1) mod N_PIPES, pipe_full_reset[old front]=1, pipe_enables[old front]=0; go to RESET_WAIT.
  - RESET_WAIT: from the second cycle on, wait for pipe_resetting[reset pipe]=1, then RESP ACK. N_PIPES=2 reproduces the ping-pong swap.
- Timeout: counter clears on each accepted byte or when programming=0. At TIMEOUT_CYCLES idle cycles while programming (any state except SWAP_WAIT/RESET_WAIT):
  - pipe_full_reset[back]=1, programming=0, any partial command dropped;
  - RESET_WAIT, then response 0x03.
- Timeout has priority over a simultaneous byte.

Optional Feature:
- Macro CONTROL_CHECKSUM_EN.
- With it: each command with a payload takes one extra trailing byte equal to the XOR of opcode and payload. On mismatch: no strobe, NAK 0x04. Payload-free commands unchanged.
- Without it: no checksum byte and no 0x04 code.

Test Plan:
- Reset release -> pipe_full_reset=2'b11 for one clk; enables=01, front=0, back=1; no strobes.
- BEGIN, then WRITE_BLOCK_INSTR blk 0x05 instr 0xDEADBEEF -> block_target=5, instr_out=0xDEADBEEF, block_instr_write=2'b10 for one cycle; two ACKs.
- WRITE_BLOCK_REG_0 without BEGIN -> resp 0x02; next byte parsed as an opcode.
- N_PIPES=3, two full program/END cycles -> front 0->1->2, resets to pipes 0 then 1, ACK after pipe_resetting.
- BEGIN then silence for TIMEOUT_CYCLES -> pipe_full_reset[back] pulse, resp 0x03, programming cleared.
- UPDATE_BLOCK_REG_1 with regfile_syncing[front]=1 for 5 cycles, and resp_ready low 3 cycles -> strobe delayed to release; resp held, in_ready low.

Source files
------------

// File: rtl/control_unit_np.sv
// control_unit_np: byte-serial host command controller driving N rotating DSP pipelines.
// Optional feature macro CONTROL_CHECKSUM_EN adds a trailing XOR checksum byte to payload commands.
`default_nettype none

module control_unit_np #(
  parameter int N_PIPES        = 2,
  parameter int N_BLOCKS       = 256,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int PW  = (N_PIPES > 2) ? $clog2(N_PIPES) : 1,
  localparam int BAW = (N_BLOCKS > 2) ? $clog2(N_BLOCKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BAW-1:0]         block_target,
  output logic                   reg_target,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [23:0]            delay_size_out,
  output logic [23:0]            init_delay_out,
  output logic [N_PIPES-1:0]     block_instr_write,
  output logic [N_PIPES-1:0]     block_reg_write,
  output logic [N_PIPES-1:0]     reg_writes_commit,
  output logic [N_PIPES-1:0]     alloc_delay,
  output logic [N_PIPES-1:0]     pipe_full_reset,
  output logic [N_PIPES-1:0]     pipe_enables,
  input  logic [N_PIPES-1:0]     regfile_syncing,
  input  logic [N_PIPES-1:0]     pipe_resetting,
  output logic                   swap_req,
  input  logic                   swap_busy,
  output logic [PW-1:0]          front_pipe,
  output logic [PW-1:0]          back_pipe,
  output logic                   set_input_gain,
  output logic                   set_output_gain,
  output logic [7:0]             resp_byte,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [7:0]             control_state
);

  localparam int BB  = (N_BLOCKS > 256) ? 2 : 1;
  localparam int DB  = (DATA_WIDTH + 7) / 8;
  localparam int IB  = INSTR_WIDTH / 8;
  localparam int L_I = BB + IB;
  localparam int L_R = BB + DB;
  localparam int L_M = (L_I > L_R) ? L_I : L_R;
  localparam int PAY_BYTES = (L_M > 6) ? L_M : 6;
  localparam int PAY_W = PAY_BYTES * 8;
  localparam int CW = $clog2(PAY_BYTES + 2);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`ifdef CONTROL_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  localparam logic [7:0] OP_BEGIN  = 8'h01;
  localparam logic [7:0] OP_END    = 8'h02;
  localparam logic [7:0] OP_INSTR  = 8'h03;
  localparam logic [7:0] OP_WREG0  = 8'h04;
  localparam logic [7:0] OP_WREG1  = 8'h05;
  localparam logic [7:0] OP_ALLOC  = 8'h06;
  localparam logic [7:0] OP_UREG0  = 8'h07;
  localparam logic [7:0] OP_UREG1  = 8'h08;
  localparam logic [7:0] OP_IGAIN  = 8'h09;
  localparam logic [7:0] OP_OGAIN  = 8'h0A;
  localparam logic [7:0] OP_COMMIT = 8'h0B;

  localparam logic [7:0] RC_ACK     = 8'h00;
  localparam logic [7:0] RC_UNKNOWN = 8'h01;
  localparam logic [7:0] RC_NOPROG  = 8'h02;
  localparam logic [7:0] RC_TIMEOUT = 8'h03;
  localparam logic [7:0] RC_CHKSUM  = 8'h04;

  localparam logic [N_PIPES-1:0] ONE = N_PIPES'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LISTEN     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_RESP       = 3'd3,
    S_SWAP_WAIT  = 3'd4,
    S_RESET_WAIT = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PAY_W-1:0]   pay_q, pay_d;
  logic               prog_q, prog_d;
  logic [PW-1:0]      front_q, front_d, back_q, back_d, rpipe_q, rpipe_d;
  logic [N_PIPES-1:0] en_q, en_d, pfr_q, pfr_d;
  logic [7:0]         code_q, code_d;
  logic               first_q, first_d;
  logic [TW-1:0]      to_q, to_d;
  logic               chk_ok;
`ifdef CONTROL_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
  logic               chk_ok_q, chk_ok_d;
  assign chk_ok = chk_ok_q;
`else
  assign chk_ok = 1'b1;
`endif

  function automatic logic [N_PIPES-1:0] onehot(input logic [PW-1:0] p);
    return ONE << p;
  endfunction

  function automatic logic [CW-1:0] pay_len(input logic [7:0] op);
    case (op)
      OP_INSTR:                              return CW'(BB + IB + CHK);
      OP_WREG0, OP_WREG1, OP_UREG0, OP_UREG1: return CW'(BB + DB + CHK);
      OP_ALLOC:                              return CW'(6 + CHK);
      OP_IGAIN, OP_OGAIN:                    return CW'(DB + CHK);
      default:                               return '0;
    endcase
  endfunction

  logic          accept, elig, timeout_hit, is_ureg, stall;
  logic [PW-1:0] back_next;

  assign in_ready      = (state_q == S_IDLE) || (state_q == S_LISTEN);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_byte     = code_q;
  assign control_state = {5'b0, state_q};
  assign front_pipe    = front_q;
  assign back_pipe     = back_q;
  assign pipe_enables  = en_q;
  assign pipe_full_reset = pfr_q;

  // Payload is right-aligned: value in the low bytes, block field just above it.
  assign block_target   = (op_q == OP_INSTR) ? pay_q[INSTR_WIDTH +: BAW] : pay_q[DB*8 +: BAW];
  assign reg_target     = (op_q == OP_WREG1) || (op_q == OP_UREG1);
  assign instr_out      = pay_q[INSTR_WIDTH-1:0];
  assign data_out       = pay_q[DATA_WIDTH-1:0];
  assign delay_size_out = pay_q[47:24];
  assign init_delay_out = pay_q[23:0];

  assign accept      = in_valid && in_ready;
  assign elig        = (state_q != S_SWAP_WAIT) && (state_q != S_RESET_WAIT);
  assign timeout_hit = prog_q && elig && (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign is_ureg     = (op_q == OP_UREG0) || (op_q == OP_UREG1);
  assign stall       = swap_busy || regfile_syncing[is_ureg ? front_q : back_q];
  assign back_next   = (back_q == PW'(N_PIPES - 1)) ? '0 : back_q + 1'b1;

  always_comb begin
    state_d = state_q;  op_d = op_q;     cnt_d = cnt_q;     pay_d = pay_q;
    prog_d = prog_q;    front_d = front_q; back_d = back_q; rpipe_d = rpipe_q;
    en_d = en_q;        pfr_d = '0;      code_d = code_q;   first_d = first_q;
    to_d = to_q;
`ifdef CONTROL_CHECKSUM_EN
    xor_d = xor_q;      chk_ok_d = chk_ok_q;
`endif
    block_instr_write = '0; block_reg_write = '0; reg_writes_commit = '0;
    alloc_delay = '0; swap_req = 1'b0; set_input_gain = 1'b0; set_output_gain = 1'b0;

    if (!prog_q || accept) to_d = '0;
    else if (elig)         to_d = to_q + 1'b1;

    case (state_q)
      S_IDLE: if (accept) begin
        op_d  = in_byte;
        cnt_d = pay_len(in_byte);
`ifdef CONTROL_CHECKSUM_EN
        xor_d = in_byte;  chk_ok_d = 1'b1;
`endif
        case (in_byte)
          OP_BEGIN: begin prog_d = 1'b1; code_d = RC_ACK; state_d = S_RESP; end
          OP_INSTR, OP_WREG0, OP_WREG1, OP_ALLOC:
            if (!prog_q) begin code_d = RC_NOPROG; state_d = S_RESP; end
            else state_d = S_LISTEN;
          OP_UREG0, OP_UREG1, OP_IGAIN, OP_OGAIN: state_d = S_LISTEN;
          OP_COMMIT: state_d = S_EXECUTE;
          OP_END:
            if (prog_q) state_d = S_EXECUTE;
            else begin code_d = RC_NOPROG; state_d = S_RESP; end
          default: begin code_d = RC_UNKNOWN; state_d = S_RESP; end
        endcase
      end
      S_LISTEN: if (accept) begin
        cnt_d = cnt_q - 1'b1;
`ifdef CONTROL_CHECKSUM_EN
        xor_d = xor_q ^ in_byte;
        if (cnt_q == CW'(1)) begin
          chk_ok_d = (xor_q == in_byte);
          state_d  = S_EXECUTE;
        end else begin
          pay_d = {pay_q[PAY_W-9:0], in_byte};
        end
`else
        pay_d = {pay_q[PAY_W-9:0], in_byte};
        if (cnt_q == CW'(1)) state_d = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        code_d  = RC_ACK;
        state_d = S_RESP;
        if (!chk_ok) begin
          code_d = RC_CHKSUM;
        end else begin
          case (op_q)
            OP_INSTR: block_instr_write = onehot(back_q);
            OP_WREG0, OP_WREG1, OP_UREG0, OP_UREG1:
              if (stall) state_d = S_EXECUTE;
              else block_reg_write = onehot(is_ureg ? front_q : back_q);
            OP_ALLOC:  alloc_delay       = onehot(back_q);
            OP_IGAIN:  set_input_gain    = 1'b1;
            OP_OGAIN:  set_output_gain   = 1'b1;
            OP_COMMIT: reg_writes_commit = onehot(front_q);
            OP_END: begin
              swap_req          = 1'b1;
              reg_writes_commit = onehot(back_q);
              en_d              = en_q | onehot(back_q);
              prog_d            = 1'b0;
              first_d           = 1'b1;
              state_d           = S_SWAP_WAIT;
            end
            default: ;
          endcase
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      S_SWAP_WAIT:
        if (first_q) first_d = 1'b0;
        else if (!swap_busy) begin
          front_d = back_q;
          back_d  = back_next;
          rpipe_d = front_q;
          pfr_d   = onehot(front_q);
          en_d    = en_q & ~onehot(front_q);
          first_d = 1'b1;
          state_d = S_RESET_WAIT;
        end
      S_RESET_WAIT:
        if (first_q) first_d = 1'b0;
        else if (pipe_resetting[rpipe_q]) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase

    // Timeout abandons whatever is in flight, including a byte accepted this cycle.
    if (timeout_hit) begin
      block_instr_write = '0; block_reg_write = '0; reg_writes_commit = '0;
      alloc_delay = '0; swap_req = 1'b0; set_input_gain = 1'b0; set_output_gain = 1'b0;
      en_d = en_q; front_d = front_q; back_d = back_q; pay_d = pay_q;
      pfr_d   = onehot(back_q);
      prog_d  = 1'b0;
      rpipe_d = back_q;
      code_d  = RC_TIMEOUT;
      first_d = 1'b1;
      to_d    = '0;
      state_d = S_RESET_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  op_q <= '0;     cnt_q <= '0;    pay_q <= '0;
      prog_q <= 1'b0;     front_q <= '0;  back_q <= PW'(1); rpipe_q <= '0;
      en_q <= ONE;        pfr_q <= '1;    code_q <= '0;   first_q <= 1'b0;
      to_q <= '0;
`ifdef CONTROL_CHECKSUM_EN
      xor_q <= '0;        chk_ok_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d; op_q <= op_d;       cnt_q <= cnt_d;   pay_q <= pay_d;
      prog_q <= prog_d;   front_q <= front_d; back_q <= back_d; rpipe_q <= rpipe_d;
      en_q <= en_d;       pfr_q <= pfr_d;     code_q <= code_d; first_q <= first_d;
      to_q <= to_d;
`ifdef CONTROL_CHECKSUM_EN
      xor_q <= xor_d;     chk_ok_q <= chk_ok_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit_np.sv
// Bench for control_unit_np (three pipelines, short timeout): randomized commands vs. a command-level model.
`default_nettype none

module tb_control_unit_np;

  localparam int NP = 3;
  localparam int TO = 60;

  localparam logic [7:0] OP_BEGIN  = 8'h01, OP_END   = 8'h02, OP_INSTR = 8'h03;
  localparam logic [7:0] OP_WREG0  = 8'h04, OP_WREG1 = 8'h05, OP_ALLOC = 8'h06;
  localparam logic [7:0] OP_UREG0  = 8'h07, OP_UREG1 = 8'h08, OP_IGAIN = 8'h09;
  localparam logic [7:0] OP_OGAIN  = 8'h0A, OP_COMMIT = 8'h0B;

  localparam logic [3:0] K_INSTR = 1, K_REG = 2, K_COMMIT = 3, K_ALLOC = 4;
  localparam logic [3:0] K_IG = 5, K_OG = 6, K_SWAP = 7, K_PFR = 8;

  typedef struct packed {
    logic [3:0]    kind;
    logic [NP-1:0] vec;
    logic [7:0]    blk;
    logic          rt;
    logic [31:0]   val;
    logic [23:0]   init;
  } ev_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] in_byte = '0;
  logic in_valid = 1'b0, in_ready;
  logic [7:0] block_target;
  logic reg_target;
  logic [31:0] instr_out;
  logic [15:0] data_out;
  logic [23:0] delay_size_out, init_delay_out;
  logic [NP-1:0] block_instr_write, block_reg_write, reg_writes_commit, alloc_delay;
  logic [NP-1:0] pipe_full_reset, pipe_enables;
  logic [NP-1:0] regfile_syncing = '0, pipe_resetting = '0;
  logic swap_req, swap_busy = 1'b0;
  logic [1:0] front_pipe, back_pipe;
  logic set_input_gain, set_output_gain;
  logic [7:0] resp_byte;
  logic resp_valid, resp_ready = 1'b0;
  logic [7:0] control_state;

  control_unit_np #(.N_PIPES(NP), .N_BLOCKS(256), .DATA_WIDTH(16), .INSTR_WIDTH(32),
                    .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .block_target(block_target), .reg_target(reg_target), .instr_out(instr_out),
    .data_out(data_out), .delay_size_out(delay_size_out), .init_delay_out(init_delay_out),
    .block_instr_write(block_instr_write), .block_reg_write(block_reg_write),
    .reg_writes_commit(reg_writes_commit), .alloc_delay(alloc_delay),
    .pipe_full_reset(pipe_full_reset), .pipe_enables(pipe_enables),
    .regfile_syncing(regfile_syncing), .pipe_resetting(pipe_resetting),
    .swap_req(swap_req), .swap_busy(swap_busy), .front_pipe(front_pipe), .back_pipe(back_pipe),
    .set_input_gain(set_input_gain), .set_output_gain(set_output_gain),
    .resp_byte(resp_byte), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .control_state(control_state));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0, last_acc = 0;
  logic mon_en = 1'b0;
  ev_t log_q[$], exp_q[$];

  // Model state: what the controller should look like at command granularity.
  logic          mprog = 1'b0;
  int            mfront = 0, mback = 1;
  logic [NP-1:0] men = 3'b001;

  always @(negedge clk) if (mon_en) begin
    if (block_instr_write != '0) log_q.push_back('{K_INSTR, block_instr_write, block_target, 1'b0, instr_out, 24'd0});
    if (block_reg_write != '0)   log_q.push_back('{K_REG, block_reg_write, block_target, reg_target, {16'd0, data_out}, 24'd0});
    if (swap_req)                log_q.push_back('{K_SWAP, reg_writes_commit, 8'd0, 1'b0, 32'd0, 24'd0});
    else if (reg_writes_commit != '0) log_q.push_back('{K_COMMIT, reg_writes_commit, 8'd0, 1'b0, 32'd0, 24'd0});
    if (alloc_delay != '0)       log_q.push_back('{K_ALLOC, alloc_delay, 8'd0, 1'b0, {8'd0, delay_size_out}, init_delay_out});
    if (set_input_gain)          log_q.push_back('{K_IG, 3'b000, 8'd0, 1'b0, {16'd0, data_out}, 24'd0});
    if (set_output_gain)         log_q.push_back('{K_OG, 3'b000, 8'd0, 1'b0, {16'd0, data_out}, 24'd0});
    if (pipe_full_reset != '0)   log_q.push_back('{K_PFR, pipe_full_reset, 8'd0, 1'b0, 32'd0, 24'd0});
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    return NP'(1) << p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 1)) tick;
    in_byte = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick; n++; end
    chk("in_ready_wait", in_ready, 1);
    tick;
    last_acc = cyc;
    in_valid = 1'b0; in_byte = '0;
  endtask

  task automatic expect_resp(input logic [7:0] code, input string tag);
    int n = 0;
    while (!resp_valid && n < 300) begin tick; n++; end
    chk({tag, "_valid"}, resp_valid, 1);
    chk(tag, resp_byte, code);
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
  endtask

  task automatic check_events(input string tag);
    ev_t e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (log_q.size() > 0) ? log_q.pop_front() : '0;
      chk({tag, "_event"}, g, e);
    end
    chk({tag, "_extra_events"}, log_q.size(), 0);
    log_q.delete();
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] blk, input logic [31:0] v,
                         input logic [31:0] w, input string tag);
    logic [7:0] pl[$];
    logic [7:0] code = 8'h00;
    case (op)
      OP_BEGIN: mprog = 1'b1;
      OP_INSTR:
        if (!mprog) code = 8'h02;
        else begin
          pl = '{blk, v[31:24], v[23:16], v[15:8], v[7:0]};
          exp_q.push_back('{K_INSTR, oh(mback), blk, 1'b0, v, 24'd0});
        end
      OP_WREG0, OP_WREG1:
        if (!mprog) code = 8'h02;
        else begin
          pl = '{blk, v[15:8], v[7:0]};
          exp_q.push_back('{K_REG, oh(mback), blk, op == OP_WREG1, {16'd0, v[15:0]}, 24'd0});
        end
      OP_UREG0, OP_UREG1: begin
        pl = '{blk, v[15:8], v[7:0]};
        exp_q.push_back('{K_REG, oh(mfront), blk, op == OP_UREG1, {16'd0, v[15:0]}, 24'd0});
      end
      OP_ALLOC:
        if (!mprog) code = 8'h02;
        else begin
          pl = '{v[23:16], v[15:8], v[7:0], w[23:16], w[15:8], w[7:0]};
          exp_q.push_back('{K_ALLOC, oh(mback), 8'd0, 1'b0, {8'd0, v[23:0]}, w[23:0]});
        end
      OP_IGAIN, OP_OGAIN: begin
        pl = '{v[15:8], v[7:0]};
        exp_q.push_back('{(op == OP_IGAIN) ? K_IG : K_OG, 3'b000, 8'd0, 1'b0, {16'd0, v[15:0]}, 24'd0});
      end
      OP_COMMIT: exp_q.push_back('{K_COMMIT, oh(mfront), 8'd0, 1'b0, 32'd0, 24'd0});
      default: code = 8'h01;
    endcase
    send_byte(op);
    foreach (pl[i]) send_byte(pl[i]);
    expect_resp(code, tag);
    check_events(tag);
  endtask

  task automatic do_end(input string tag);
    int n = 0;
    int old;
    if (!mprog) begin
      send_byte(OP_END);
      expect_resp(8'h02, tag);
      check_events(tag);
    end else begin
      exp_q.push_back('{K_SWAP, oh(mback), 8'd0, 1'b0, 32'd0, 24'd0});
      exp_q.push_back('{K_PFR, oh(mfront), 8'd0, 1'b0, 32'd0, 24'd0});
      send_byte(OP_END);
      swap_busy = 1'b1;
      repeat (4) tick;
      chk({tag, "_held_by_busy"}, {pipe_full_reset, control_state}, {3'b000, 8'd4});
      swap_busy = 1'b0;
      while (pipe_full_reset == '0 && n < 50) begin tick; n++; end
      chk({tag, "_reset_pulse"}, pipe_full_reset, oh(mfront));
      old    = mfront;
      men    = (men | oh(mback)) & ~oh(mfront);
      mfront = mback;
      mback  = (mback + 1) % NP;
      mprog  = 1'b0;
      repeat (3) tick;
      chk({tag, "_no_early_ack"}, resp_valid, 0);
      pipe_resetting = oh(old);
      expect_resp(8'h00, tag);
      pipe_resetting = '0;
      check_events(tag);
      chk({tag, "_front"}, front_pipe, mfront);
      chk({tag, "_back"}, back_pipe, mback);
      chk({tag, "_enables"}, pipe_enables, men);
    end
  endtask

  initial begin
    logic [7:0] ops [9] = '{OP_INSTR, OP_WREG0, OP_WREG1, OP_ALLOC, OP_UREG0,
                             OP_UREG1, OP_IGAIN, OP_OGAIN, OP_COMMIT};
    int exp_front [3] = '{1, 2, 0};
    int n;

    // Reset behaviour, including the post-release reset pulse.
    repeat (3) @(posedge clk);
    #1;
    chk("pfr_in_reset", pipe_full_reset, 3'b111);
    reset_n = 1'b1;
    chk("pfr_after_release", pipe_full_reset, 3'b111);
    chk("reset_front_back", {front_pipe, back_pipe}, {2'd0, 2'd1});
    chk("reset_enables", pipe_enables, 3'b001);
    chk("reset_state", {control_state, resp_valid, in_ready}, {8'd0, 1'b0, 1'b1});
    tick;
    chk("pfr_cleared", pipe_full_reset, 3'b000);
    chk("reset_strobes", {block_instr_write, block_reg_write, reg_writes_commit, alloc_delay,
                          swap_req, set_input_gain, set_output_gain}, '0);
    mon_en = 1'b1;

    // Programming-only command without BEGIN; the following byte must parse as an opcode.
    run_cmd(OP_WREG0, 8'h12, 32'h3456, 0, "wreg_noprog");
    run_cmd(OP_COMMIT, 0, 0, 0, "commit_after_nak");
    run_cmd(8'hEE, 0, 0, 0, "unknown_op");
    do_end("end_noprog");

    run_cmd(OP_BEGIN, 0, 0, 0, "begin0");
    run_cmd(OP_INSTR, 8'h05, 32'hDEADBEEF, 0, "instr_directed");

    // Three randomized program rounds, each closed by END and a pipe rotation.
    for (int r = 0; r < 3; r++) begin
      if (r > 0) run_cmd(OP_BEGIN, 0, 0, 0, "begin_r");
      for (int k = 0; k < 8; k++) begin
        run_cmd(ops[$urandom_range(0, 8)], 8'($urandom), $urandom, $urandom, "rand_cmd");
        repeat ($urandom_range(0, 3)) tick;
      end
      do_end("swap");
      chk("round_front", front_pipe, exp_front[r]);
    end

    // Register update stalled by regfile sync, response held by resp_ready.
    regfile_syncing = oh(mfront);
    exp_q.push_back('{K_REG, oh(mfront), 8'h3C, 1'b1, 32'h0000A55A, 24'd0});
    send_byte(OP_UREG1); send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h5A);
    repeat (5) tick;
    chk("stall_no_strobe", log_q.size(), 0);
    chk("stall_state", control_state, 8'd2);
    regfile_syncing = '0;
    n = 0;
    while (!resp_valid && n < 20) begin tick; n++; end
    for (int i = 0; i < 3; i++) begin
      chk("resp_held", {resp_valid, in_ready}, {1'b1, 1'b0});
      tick;
    end
    expect_resp(8'h00, "stall_resp");
    check_events("stall");

    // Timeout while programming.
    run_cmd(OP_BEGIN, 0, 0, 0, "begin_to");
    n = 0;
    while (pipe_full_reset == '0 && n < 300) begin tick; n++; end
    chk("timeout_pfr", pipe_full_reset, oh(mback));
    chk("timeout_latency", cyc - last_acc, TO);
    exp_q.push_back('{K_PFR, oh(mback), 8'd0, 1'b0, 32'd0, 24'd0});
    mprog = 1'b0;
    tick; tick;
    pipe_resetting = oh(mback);
    expect_resp(8'h03, "timeout_resp");
    pipe_resetting = '0;
    check_events("timeout");
    run_cmd(OP_ALLOC, 0, 32'h123456, 32'h654321, "alloc_after_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
